// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC frame sequencer: FSM state encoding,
// status-word field offsets and default parameter values.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    CONV = 2'd2,
    EMIT = 2'd3
  } seq_state_e;

  // Status word: {frame_seq, err_mask, 4'h0, n, 8'h00}
  localparam int STAT_SEQ_LSB = 24;
  localparam int STAT_ERR_LSB = 16;
  localparam int STAT_N_LSB   = 8;

  localparam int DEF_NUM_CH_MAX  = 8;
  localparam int DEF_ADC_W       = 24;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_FIFO_DEPTH  = 16;
  localparam int DEF_PERIOD_W    = 24;

  function automatic logic [31:0] status_word(input logic [7:0] seq,
                                              input logic [7:0] err,
                                              input logic [3:0] n);
    logic [31:0] w;
    w = '0;
    w[STAT_SEQ_LSB +: 8] = seq;
    w[STAT_ERR_LSB +: 8] = err;
    w[STAT_N_LSB +: 4]   = n;
    return w;
  endfunction

endpackage

// File: rtl/adc_seq_trigger.sv
// Trigger merge for the ADC frame sequencer: period timer, start/timer merge,
// one-deep pending flag and missed-trigger reporting.
module adc_seq_trigger
  import adc_seq_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                enable,
  input  logic                start,
  input  logic [PERIOD_W-1:0] period,
  input  logic                idle,
  output logic                trig,
  output logic                drop_inc
);

  logic [PERIOD_W-1:0] timer_reg;
  logic                pending_reg;
  logic                pending_next;
  logic                period_on;
  logic                timer_wrap;
  logic                trig_req;

  assign period_on  = enable && (period != '0);
  assign timer_wrap = period_on && (timer_reg == period - PERIOD_W'(1));
  // start is only honoured while enabled; a disabled start is not a drop
  assign trig_req   = enable && (start || timer_wrap);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      timer_reg <= '0;
    end else if (!period_on || timer_wrap) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + PERIOD_W'(1);
    end
  end

  always_comb begin
    trig         = 1'b0;
    drop_inc     = 1'b0;
    pending_next = pending_reg;
    if (idle) begin
      if (!enable) begin
        pending_next = 1'b0;
      end else if (pending_reg) begin
        // consume the pending trigger; a coincident new one takes its slot
        trig         = 1'b1;
        pending_next = trig_req;
      end else begin
        trig = trig_req;
      end
    end else if (trig_req) begin
      if (pending_reg) begin
        drop_inc = 1'b1;
      end else begin
        pending_next = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pending_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
    end
  end

endmodule

// File: rtl/adc_frame_sequencer.sv
// ADC frame sequencer: converts n channels, then emits {status, CH0..CHn-1}
// atomically into the streaming FIFO. Optional ADC_SEQ_TARE_EN subtracts a per-channel tare.
module adc_frame_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH_MAX  = DEF_NUM_CH_MAX,
  parameter int ADC_W       = DEF_ADC_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int PERIOD_W    = DEF_PERIOD_W
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                enable,
  input  logic                start,
  input  logic [3:0]          num_ch,
  input  logic [PERIOD_W-1:0] period,
  output logic                conv_req,
  output logic [2:0]          conv_ch,
  input  logic                conv_valid,
  input  logic [ADC_W-1:0]    conv_data,
  input  logic [4:0]          fifo_level,
  output logic                fifo_wvalid,
  output logic [31:0]         fifo_wdata,
  input  logic                fifo_wready,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          frame_seq,
  output logic [15:0]         drop_count
`ifdef ADC_SEQ_TARE_EN
  ,
  input  logic [NUM_CH_MAX*32-1:0] tare_flat
`endif
);

  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;

  seq_state_e  state_reg;
  seq_state_e  state_next;
  logic        trig;
  logic        trig_drop;
  logic        fsm_drop;
  logic [3:0]  n_clamp;
  logic        space_ok;
  logic [3:0]  idx_reg;
  logic [3:0]  n_reg;
  logic [TO_W-1:0] cnt_reg;
  logic        gap_reg;
  logic [7:0]  err_mask_reg;
  logic [3:0]  word_idx_reg;
  logic [7:0]  frame_seq_reg;
  logic [15:0] drop_reg;
  logic [16:0] drop_sum;
  logic        frame_done_reg;
  logic        timeout_hit;
  logic        last_ch;
  logic        last_word;
  logic        sample_we;
  logic [31:0] sample_wdata;
  logic [2:0]  word_sel;
  logic [31:0] samples_reg [NUM_CH_MAX];
  logic [31:0] out_word    [NUM_CH_MAX];

  adc_seq_trigger #(
    .PERIOD_W (PERIOD_W)
  ) u_trigger (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .enable    (enable),
    .start     (start),
    .period    (period),
    .idle      (state_reg == IDLE),
    .trig      (trig),
    .drop_inc  (trig_drop)
  );

  assign n_clamp  = (num_ch == 4'd0 || num_ch > 4'(NUM_CH_MAX)) ? 4'(NUM_CH_MAX) : num_ch;
  // whole frame (status + n samples) must fit, or nothing is written
  assign space_ok = ({2'b00, fifo_level} + {3'b000, n_clamp} + 7'd1) <= 7'(FIFO_DEPTH);

  assign timeout_hit  = (cnt_reg == TO_W'(TIMEOUT_CYC - 1));
  assign last_ch      = (idx_reg + 4'd1) == n_reg;
  assign last_word    = (word_idx_reg == n_reg);
  assign sample_we    = (state_reg == CONV) && enable && !gap_reg && (conv_valid || timeout_hit);
  assign sample_wdata = conv_valid ? {{(32-ADC_W){conv_data[ADC_W-1]}}, conv_data} : 32'h0;
  assign word_sel     = word_idx_reg[2:0] - 3'd1;

  always_comb begin
    state_next = state_reg;
    fsm_drop   = 1'b0;
    case (state_reg)
      IDLE: if (trig) state_next = ARM;
      ARM: begin
        if (space_ok) begin
          state_next = CONV;
        end else begin
          state_next = IDLE;
          fsm_drop   = 1'b1;
        end
      end
      CONV: begin
        if (!enable) begin
          state_next = IDLE;
          fsm_drop   = 1'b1;
        end else if (gap_reg && last_ch) begin
          state_next = EMIT;
        end
      end
      EMIT: if (fifo_wready && last_word) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign drop_sum = {1'b0, drop_reg} + {16'd0, trig_drop} + {16'd0, fsm_drop};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      n_reg          <= '0;
      cnt_reg        <= '0;
      gap_reg        <= 1'b0;
      err_mask_reg   <= '0;
      word_idx_reg   <= '0;
      frame_seq_reg  <= '0;
      drop_reg       <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      drop_reg       <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      frame_done_reg <= 1'b0;
      case (state_reg)
        ARM: begin
          n_reg        <= n_clamp;
          idx_reg      <= '0;
          cnt_reg      <= '0;
          gap_reg      <= 1'b0;
          err_mask_reg <= '0;
          word_idx_reg <= '0;
        end
        CONV: begin
          if (enable) begin
            if (gap_reg) begin
              gap_reg <= 1'b0;
              cnt_reg <= '0;
              idx_reg <= idx_reg + 4'd1;
            end else if (conv_valid) begin
              gap_reg <= 1'b1;
            end else if (timeout_hit) begin
              gap_reg                    <= 1'b1;
              err_mask_reg[idx_reg[2:0]] <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + TO_W'(1);
            end
          end
        end
        EMIT: begin
          if (fifo_wready) begin
            if (last_word) begin
              frame_done_reg <= 1'b1;
              frame_seq_reg  <= frame_seq_reg + 8'd1;
              err_mask_reg   <= '0;
            end else begin
              word_idx_reg <= word_idx_reg + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sample store needs no reset: every slot read out is rewritten in the same frame
  always_ff @(posedge wb_clk_i) begin
    if (sample_we) samples_reg[idx_reg[2:0]] <= sample_wdata;
  end

  for (genvar gi = 0; gi < NUM_CH_MAX; gi++) begin : g_word
`ifdef ADC_SEQ_TARE_EN
    assign out_word[gi] = err_mask_reg[gi] ? 32'h0 : (samples_reg[gi] - tare_flat[gi*32 +: 32]);
`else
    assign out_word[gi] = samples_reg[gi];
`endif
  end

  assign conv_req    = (state_reg == CONV) && !gap_reg;
  assign conv_ch     = (state_reg == CONV) ? idx_reg[2:0] : 3'd0;
  assign fifo_wvalid = (state_reg == EMIT);
  assign fifo_wdata  = (state_reg != EMIT) ? 32'h0 :
                       (word_idx_reg == 4'd0) ? status_word(frame_seq_reg, err_mask_reg, n_reg) :
                       out_word[word_sel];
  assign busy        = (state_reg != IDLE);
  assign frame_done  = frame_done_reg;
  assign frame_seq   = frame_seq_reg;
  assign drop_count  = drop_reg;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Directed self-checking bench for adc_frame_sequencer (TIMEOUT_CYC=16).
`timescale 1ns/1ps
module tb_adc_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_ch = 4'd0;
  logic [23:0] period = 24'd0;
  logic        conv_req;
  logic [2:0]  conv_ch;
  logic        conv_valid = 1'b0;
  logic [23:0] conv_data = 24'd0;
  logic [4:0]  fifo_level = 5'd0;
  logic        fifo_wvalid;
  logic [31:0] fifo_wdata;
  logic        fifo_wready = 1'b1;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_seq;
  logic [15:0] drop_count;
`ifdef ADC_SEQ_TARE_EN
  logic [255:0] tare_flat = '0;
`endif

  int checks = 0;
  int errors = 0;

  // responder / ready-driver controls (written by tasks only)
  logic [23:0] resp_data [8];
  logic [7:0]  resp_mute = 8'h00;
  int          resp_delay = 0;
  logic        wr_level = 1'b1;
  logic        wr_toggle = 1'b0;

  // monitor state (written by monitor only)
  logic [31:0] words_q [$];
  int          start_q [$];
  int          done_cnt = 0;
  int          stall_cnt = 0;
  int          stall_viol = 0;
  int          cyc = 0;
  int          req_age = 0;
  logic        stall_pending = 1'b0;
  logic [31:0] stall_word = 32'h0;
  logic        busy_prev = 1'b0;

  adc_frame_sequencer #(
    .TIMEOUT_CYC (16)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .enable      (enable),
    .start       (start),
    .num_ch      (num_ch),
    .period      (period),
    .conv_req    (conv_req),
    .conv_ch     (conv_ch),
    .conv_valid  (conv_valid),
    .conv_data   (conv_data),
    .fifo_level  (fifo_level),
    .fifo_wvalid (fifo_wvalid),
    .fifo_wdata  (fifo_wdata),
    .fifo_wready (fifo_wready),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_seq   (frame_seq),
    .drop_count  (drop_count)
`ifdef ADC_SEQ_TARE_EN
    ,
    .tare_flat   (tare_flat)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ADC front-end model: answers resp_delay cycles into each request
  always @(negedge clk) begin
    if (conv_req) begin
      conv_valid = (req_age == resp_delay) && !resp_mute[conv_ch];
      conv_data  = conv_valid ? resp_data[conv_ch] : 24'd0;
      req_age    = req_age + 1;
    end else begin
      conv_valid = 1'b0;
      conv_data  = 24'd0;
      req_age    = 0;
    end
  end

  always @(negedge clk) begin
    if (wr_toggle) fifo_wready = ~fifo_wready;
    else           fifo_wready = wr_level;
  end

  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (fifo_wvalid && fifo_wready) words_q.push_back(fifo_wdata);
      if (stall_pending && fifo_wvalid && (fifo_wdata !== stall_word)) stall_viol = stall_viol + 1;
      if (fifo_wvalid && !fifo_wready) stall_cnt = stall_cnt + 1;
      stall_pending = fifo_wvalid && !fifo_wready;
      stall_word    = fifo_wdata;
      if (frame_done) done_cnt = done_cnt + 1;
      if (busy && !busy_prev) start_q.push_back(cyc);
      busy_prev = busy;
    end else begin
      stall_pending = 1'b0;
      busy_prev     = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0; start = 1'b0; num_ch = 4'd0; period = 24'd0; fifo_level = 5'd0;
    wr_level = 1'b1; wr_toggle = 1'b0; resp_delay = 0; resp_mute = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && done_cnt < target; i++) tick();
    ok = (done_cnt >= target);
  endtask

  function automatic logic [31:0] word_at(input int idx);
    if (idx < words_q.size()) return words_q[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; start = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (conv_req !== 1'b0 || conv_ch !== 3'd0) begin errors++; $display("FAIL reset_conv: got req=%0b ch=%0d want 0/0", conv_req, conv_ch); end
    checks++; if (fifo_wvalid !== 1'b0 || fifo_wdata !== 32'h0) begin errors++; $display("FAIL reset_fifo: got v=%0b d=%h want 0/0", fifo_wvalid, fifo_wdata); end
    checks++; if (frame_done !== 1'b0 || frame_seq !== 8'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL reset_counters: got done=%0b seq=%0d drop=%0d want 0", frame_done, frame_seq, drop_count); end
    start = 1'b0;
    do_reset();
    // start while disabled: ignored and not counted
    pulse_start();
    tick();
    checks++; if (busy !== 1'b0 || drop_count !== 16'd0) begin errors++; $display("FAIL start_disabled: got busy=%0b drop=%0d want 0/0", busy, drop_count); end
    $display("test_reset done");
  endtask

  task automatic test_basic_frame();
    logic [31:0] exp_w [5] = '{32'h00000400, 32'hFF800001, 32'h00000010, 32'h007FFFFF, 32'h00000000};
    int wb, db;
    bit ok;
    do_reset();
    resp_data[0] = 24'h800001; resp_data[1] = 24'h000010;
    resp_data[2] = 24'h7FFFFF; resp_data[3] = 24'h000000;
    resp_delay = 3; num_ch = 4'd4; enable = 1'b1;
    wb = words_q.size(); db = done_cnt;
    pulse_start();
    wait_done(db + 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: frame_done not seen within 200 cycles"); end
    tick(); tick();
    checks++; if (words_q.size() - wb !== 5) begin errors++; $display("FAIL basic_count: got %0d words want 5", words_q.size() - wb); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (word_at(wb + i) !== exp_w[i]) begin errors++; $display("FAIL basic_word%0d: got %h want %h", i, word_at(wb + i), exp_w[i]); end
    end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL basic_done_pulse: got %0d high cycles want 1", done_cnt - db); end
    checks++; if (frame_seq !== 8'd1) begin errors++; $display("FAIL basic_seq: got %0d want 1", frame_seq); end
    $display("test_basic_frame done");
  endtask

  task automatic test_no_space();
    int wb, db;
    bit ok;
    do_reset();
    num_ch = 4'd8; fifo_level = 5'd8; enable = 1'b1;
    wb = words_q.size();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nospace_arm: got busy=%0b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nospace_idle: got busy=%0b want 0", busy); end
    tick(); tick();
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL nospace_drop: got %0d want 1", drop_count); end
    checks++; if (words_q.size() !== wb) begin errors++; $display("FAIL nospace_words: got %0d words want 0", words_q.size() - wb); end
    // exactly n+1 free with num_ch=0 clamping to 8
    fifo_level = 5'd7; num_ch = 4'd0; resp_delay = 0;
    for (int i = 0; i < 8; i++) resp_data[i] = 24'(i + 1);
    wb = words_q.size(); db = done_cnt;
    pulse_start();
    wait_done(db + 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fit_timeout: frame_done not seen within 200 cycles"); end
    checks++; if (words_q.size() - wb !== 9) begin errors++; $display("FAIL fit_count: got %0d words want 9", words_q.size() - wb); end
    checks++; if (word_at(wb) !== 32'h00000800) begin errors++; $display("FAIL fit_status: got %h want 00000800", word_at(wb)); end
    checks++; if (word_at(wb + 8) !== 32'h00000008) begin errors++; $display("FAIL fit_ch7: got %h want 00000008", word_at(wb + 8)); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL fit_drop: got %0d want 1", drop_count); end
    $display("test_no_space done");
  endtask

  task automatic test_timeout();
    int wb, db, hi;
    bit ok;
    do_reset();
    num_ch = 4'd2; resp_mute = 8'b0000_0010; resp_data[0] = 24'h123456; resp_delay = 0; enable = 1'b1;
    wb = words_q.size(); db = done_cnt;
    pulse_start();
    for (int i = 0; i < 50 && !(conv_req && conv_ch == 3'd1); i++) tick();
    checks++; if (!(conv_req && conv_ch == 3'd1)) begin errors++; $display("FAIL to_req_ch1: got req=%0b ch=%0d want 1/1", conv_req, conv_ch); end
    hi = 0;
    while (conv_req && hi < 100) begin hi++; tick(); end
    checks++; if (hi !== 16) begin errors++; $display("FAIL to_req_len: got %0d cycles want 16", hi); end
    checks++; if (conv_req !== 1'b0 || fifo_wvalid !== 1'b0) begin errors++; $display("FAIL to_gap: got req=%0b wvalid=%0b want 0/0", conv_req, fifo_wvalid); end
    tick();
    checks++; if (fifo_wvalid !== 1'b1) begin errors++; $display("FAIL to_emit: got wvalid=%0b want 1", fifo_wvalid); end
    wait_done(db + 1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_done: frame_done not seen within 100 cycles"); end
    checks++; if (word_at(wb) !== 32'h00020200) begin errors++; $display("FAIL to_status: got %h want 00020200", word_at(wb)); end
    checks++; if (word_at(wb + 1) !== 32'h00123456) begin errors++; $display("FAIL to_ch0: got %h want 00123456", word_at(wb + 1)); end
    checks++; if (word_at(wb + 2) !== 32'h00000000) begin errors++; $display("FAIL to_ch1: got %h want 00000000", word_at(wb + 2)); end
    $display("test_timeout done");
  endtask

  task automatic test_periodic();
    int wb, db, sb, bad, avail;
    bit ok;
    do_reset();
    num_ch = 4'd1; resp_delay = 0; resp_data[0] = 24'h000055;
    wb = words_q.size(); db = done_cnt; sb = start_q.size();
    period = 24'd100; enable = 1'b1;
    wait_done(db + 256, 256 * 100 + 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL per_timeout: got %0d frames want 256", done_cnt - db); end
    checks++; if (frame_seq !== 8'd0) begin errors++; $display("FAIL per_seq_wrap: got %0d want 0", frame_seq); end
    checks++; if (word_at(wb) !== 32'h00000100 || word_at(wb + 1) !== 32'h00000055) begin errors++; $display("FAIL per_first: got %h %h want 00000100 00000055", word_at(wb), word_at(wb + 1)); end
    checks++; if (word_at(wb + 510) !== 32'hFF000100) begin errors++; $display("FAIL per_last_status: got %h want FF000100", word_at(wb + 510)); end
    avail = start_q.size() - sb;
    bad = (avail < 256) ? 1 : 0;
    for (int i = 1; i < 256 && i < avail; i++)
      if (start_q[sb + i] - start_q[sb + i - 1] != 100) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL per_spacing: got %0d bad intervals (of %0d starts) want 0", bad, avail); end
    period = 24'd0; enable = 1'b0;
    tick(); tick();
    $display("test_periodic done");
  endtask

  task automatic test_pending_abort();
    int wb, db;
    bit ok;
    do_reset();
    num_ch = 4'd1; resp_delay = 6; resp_data[0] = 24'hABCDEF; enable = 1'b1;
    wb = words_q.size(); db = done_cnt;
    pulse_start();
    tick();
    pulse_start();
    pulse_start();
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL pend_drop: got %0d want 1", drop_count); end
    wait_done(db + 2, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pend_timeout: got %0d frames want 2", done_cnt - db); end
    for (int i = 0; i < 40; i++) tick();
    checks++; if (done_cnt - db !== 2) begin errors++; $display("FAIL pend_frames: got %0d want 2", done_cnt - db); end
    checks++; if (words_q.size() - wb !== 4) begin errors++; $display("FAIL pend_count: got %0d words want 4", words_q.size() - wb); end
    checks++; if (word_at(wb + 2) !== 32'h01000100 || word_at(wb + 3) !== 32'hFFABCDEF) begin errors++; $display("FAIL pend_second: got %h %h want 01000100 FFABCDEF", word_at(wb + 2), word_at(wb + 3)); end
    // enable dropped mid-CONV
    num_ch = 4'd2; resp_delay = 10;
    wb = words_q.size(); db = done_cnt;
    pulse_start();
    for (int i = 0; i < 20 && !conv_req; i++) tick();
    checks++; if (conv_req !== 1'b1) begin errors++; $display("FAIL abort_req: got %0b want 1", conv_req); end
    tick(); tick();
    enable = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0 || conv_req !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%0b req=%0b want 0/0", busy, conv_req); end
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL abort_drop: got %0d want 2", drop_count); end
    for (int i = 0; i < 20; i++) tick();
    checks++; if (words_q.size() !== wb || done_cnt !== db) begin errors++; $display("FAIL abort_words: got %0d words %0d done want 0/0", words_q.size() - wb, done_cnt - db); end
    $display("test_pending_abort done");
  endtask

  task automatic test_backpressure_reset();
    logic [31:0] exp_w [4] = '{32'h00000300, 32'h00000001, 32'hFFFFFFFE, 32'h00400000};
    int wb, db, vb, sc;
    bit ok;
    do_reset();
    num_ch = 4'd3; resp_delay = 1; enable = 1'b1;
    resp_data[0] = 24'h000001; resp_data[1] = 24'hFFFFFE; resp_data[2] = 24'h400000;
    wb = words_q.size(); db = done_cnt; vb = stall_viol; sc = stall_cnt;
    wr_toggle = 1'b1;
    pulse_start();
    wait_done(db + 1, 200, ok);
    wr_toggle = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: frame_done not seen within 200 cycles"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (word_at(wb + i) !== exp_w[i]) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, word_at(wb + i), exp_w[i]); end
    end
    checks++; if (stall_cnt == sc) begin errors++; $display("FAIL bp_stalled: got 0 stall cycles want >0"); end
    checks++; if (stall_viol !== vb) begin errors++; $display("FAIL bp_stable: got %0d data changes while stalled want 0", stall_viol - vb); end
    // reset while stalled in EMIT
    wr_level = 1'b0;
    tick();
    pulse_start();
    for (int i = 0; i < 50 && !fifo_wvalid; i++) tick();
    tick(); tick();
    checks++; if (fifo_wvalid !== 1'b1 || fifo_wdata !== 32'h01000300) begin errors++; $display("FAIL rst_pre: got v=%0b d=%h want 1/01000300", fifo_wvalid, fifo_wdata); end
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_wvalid !== 1'b0 || busy !== 1'b0 || frame_seq !== 8'd0) begin errors++; $display("FAIL rst_async: got v=%0b busy=%0b seq=%0d want 0/0/0", fifo_wvalid, busy, frame_seq); end
    tick();
    rst_n = 1'b1; wr_level = 1'b1;
    tick(); tick();
    wb = words_q.size(); db = done_cnt;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (words_q.size() !== wb) begin errors++; $display("FAIL rst_no_words: got %0d words want 0", words_q.size() - wb); end
    pulse_start();
    wait_done(db + 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_next_timeout: frame_done not seen within 200 cycles"); end
    checks++; if (words_q.size() - wb !== 4 || word_at(wb) !== 32'h00000300) begin errors++; $display("FAIL rst_next_status: got %0d words status %h want 4/00000300", words_q.size() - wb, word_at(wb)); end
    $display("test_backpressure_reset done");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_no_space();
    test_timeout();
    test_periodic();
    test_pending_abort();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
